// File: rtl/hls_stall_pkg.sv
// Shared types and helpers for the AXI-Stream stall detector.
package hls_stall_pkg;

    // Per-channel stall FSM states
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        BLOCKED = 2'd2
    } stall_state_t;

    localparam int DEF_CNT_W = 16;

    // A programmed threshold of zero behaves as one stall cycle
    function automatic logic [63:0] eff_threshold(input logic [63:0] thr);
        return (thr == 64'd0) ? 64'd1 : thr;
    endfunction

endpackage

// File: rtl/hls_stall_chan.sv
// One channel of the stall detector: FSM plus consecutive-stall counter.
// Optional macro HLS_STALL_MAX_TRACK_EN exposes the next counter value
// for the top-level longest-stall tracker.
module hls_stall_chan
    import hls_stall_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_enable,
    input  logic             i_stall,
    input  logic [CNT_W-1:0] i_threshold,
    output stall_state_t     o_state,
    output logic             o_enter
`ifdef HLS_STALL_MAX_TRACK_EN
    ,
    output logic [CNT_W-1:0] o_cnt_next
`endif
);

    stall_state_t     r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_enter;

    stall_state_t     w_state_next;
    logic [CNT_W-1:0] w_cnt_next;
    logic [CNT_W-1:0] w_cnt_inc;
    logic [CNT_W-1:0] w_eff_thr;

    assign w_eff_thr = CNT_W'(eff_threshold(64'(i_threshold)));
    assign w_cnt_inc = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;

    // Next-state and next-count decode; any non-stall cycle returns to IDLE
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        if (!i_enable) begin
            w_state_next = IDLE;
            w_cnt_next   = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_stall) begin
                        w_cnt_next   = CNT_W'(1);
                        w_state_next = (w_eff_thr == CNT_W'(1)) ? BLOCKED : WAIT;
                    end else begin
                        w_cnt_next   = '0;
                    end
                end
                WAIT: begin
                    if (i_stall) begin
                        w_cnt_next = w_cnt_inc;
                        if (w_cnt_inc >= w_eff_thr) begin
                            w_state_next = BLOCKED;
                        end
                    end else begin
                        w_state_next = IDLE;
                        w_cnt_next   = '0;
                    end
                end
                BLOCKED: begin
                    if (i_stall) begin
                        w_cnt_next = w_cnt_inc;
                    end else begin
                        w_state_next = IDLE;
                        w_cnt_next   = '0;
                    end
                end
                default: begin
                    w_state_next = IDLE;
                    w_cnt_next   = '0;
                end
            endcase
        end
    end

    // State, counter and registered entry pulse
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_enter <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_enter <= (w_state_next == BLOCKED) && (r_state != BLOCKED);
        end
    end

    assign o_state = r_state;
    assign o_enter = r_enter;
`ifdef HLS_STALL_MAX_TRACK_EN
    assign o_cnt_next = w_cnt_next;
`endif

endmodule

// File: rtl/hls_axis_stall_detector.sv
// Per-channel AXI-Stream stall detector feeding the HLS deadlock monitor.
// Handshake semantics: a beat transfers when tvalid & tready are both high;
// a producer port stalls on tvalid & ~tready, a consumer port on
// tready & ~tvalid. A transfer is never a stall.
// Optional macro HLS_STALL_MAX_TRACK_EN adds stall_max / stats_clear.
module hls_axis_stall_detector
    import hls_stall_pkg::*;
#(
    parameter int                NUM_CH   = 2,
    parameter int                CNT_W    = DEF_CNT_W,
    parameter logic [NUM_CH-1:0] DIR_MASK = 2'b10
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic [CNT_W-1:0]  threshold,
    input  logic [NUM_CH-1:0] ch_tvalid,
    input  logic [NUM_CH-1:0] ch_tready,
    output logic [NUM_CH-1:0] axis_block_sigs,
    output logic              block_event
`ifdef HLS_STALL_MAX_TRACK_EN
    ,
    output logic [CNT_W-1:0]  stall_max,
    input  logic              stats_clear
`endif
);

    logic [NUM_CH-1:0] w_stall;
    logic [NUM_CH-1:0] w_enter;
    stall_state_t      w_state [NUM_CH];
`ifdef HLS_STALL_MAX_TRACK_EN
    logic [CNT_W-1:0]  w_cnt_next [NUM_CH];
    logic [CNT_W-1:0]  w_max_next;
    logic [CNT_W-1:0]  r_stall_max;
`endif

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        assign w_stall[g] = DIR_MASK[g] ? (ch_tvalid[g] & ~ch_tready[g])
                                        : (ch_tready[g] & ~ch_tvalid[g]);

        hls_stall_chan #(
            .CNT_W (CNT_W)
        ) u_chan (
            .i_clock     (clock),
            .i_reset     (reset),
            .i_enable    (enable),
            .i_stall     (w_stall[g]),
            .i_threshold (threshold),
            .o_state     (w_state[g]),
            .o_enter     (w_enter[g])
`ifdef HLS_STALL_MAX_TRACK_EN
            ,
            .o_cnt_next  (w_cnt_next[g])
`endif
        );

        // Flag is a direct decode of the registered channel state
        assign axis_block_sigs[g] = (w_state[g] == BLOCKED);
    end

    // Simultaneous entries collapse into one pulse
    assign block_event = |w_enter;

`ifdef HLS_STALL_MAX_TRACK_EN
    // Largest of the held maximum and every channel's next count
    always_comb begin
        w_max_next = r_stall_max;
        for (int i = 0; i < NUM_CH; i++) begin
            if (w_cnt_next[i] > w_max_next) begin
                w_max_next = w_cnt_next[i];
            end
        end
    end

    // Longest-stall register; clear wins over the update
    always_ff @(posedge clock) begin
        if (reset || stats_clear) begin
            r_stall_max <= '0;
        end else begin
            r_stall_max <= w_max_next;
        end
    end

    assign stall_max = r_stall_max;
`endif

endmodule

// File: tb/tb_hls_axis_stall_detector.sv
// Directed bench for hls_axis_stall_detector (default: channel 1 producer,
// channel 0 consumer). Inputs change and outputs are sampled 1ns after the
// rising edge; "cycle k" is the interval after the k-th edge.
module tb_hls_axis_stall_detector;

    localparam int NUM_CH = 2;
    localparam int CNT_W  = 16;

    logic              clock;
    logic              reset;
    logic              enable;
    logic [CNT_W-1:0]  threshold;
    logic [NUM_CH-1:0] ch_tvalid;
    logic [NUM_CH-1:0] ch_tready;
    logic [NUM_CH-1:0] axis_block_sigs;
    logic              block_event;
`ifdef HLS_STALL_MAX_TRACK_EN
    logic [CNT_W-1:0]  stall_max;
    logic              stats_clear;
`endif

    int n_tests;
    int n_fail;
    logic [2:0] exp_q[$];

    hls_axis_stall_detector #(
        .NUM_CH   (NUM_CH),
        .CNT_W    (CNT_W),
        .DIR_MASK (2'b10)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .enable          (enable),
        .threshold       (threshold),
        .ch_tvalid       (ch_tvalid),
        .ch_tready       (ch_tready),
        .axis_block_sigs (axis_block_sigs),
        .block_event     (block_event)
`ifdef HLS_STALL_MAX_TRACK_EN
        ,
        .stall_max       (stall_max),
        .stats_clear     (stats_clear)
`endif
    );

    // Clock
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check_out(input string tag, input logic [1:0] sigs, input logic ev);
        check({tag, ".sigs"}, 32'(axis_block_sigs), 32'(sigs));
        check({tag, ".event"}, 32'(block_event), 32'(ev));
    endtask

    task automatic idle_inputs();
        ch_tvalid = 2'b00;
        ch_tready = 2'b00;
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        reset     = 1'b1;
        enable    = 1'b1;
        threshold = 16'd4;
        idle_inputs();
`ifdef HLS_STALL_MAX_TRACK_EN
        stats_clear = 1'b0;
`endif
        ticks(3);
        check_out("reset", 2'b00, 1'b0);
`ifdef HLS_STALL_MAX_TRACK_EN
        check("reset.stall_max", 32'(stall_max), 32'd0);
`endif
        reset = 1'b0;
        tick();

        // Producer stall on ch1, threshold 4, held cycles 0..5
        threshold = 16'd4;
        ch_tvalid = 2'b10;
        ch_tready = 2'b00;
        exp_q = '{3'b000, 3'b000, 3'b000, 3'b101, 3'b100, 3'b100};
        for (int k = 1; k <= 6; k++) begin
            logic [2:0] e;
            tick();
            e = exp_q.pop_front();
            check_out($sformatf("prod_stall.c%0d", k), e[2:1], e[0]);
        end
        ch_tready = 2'b10;                      // handshake in cycle 6
        tick();
        check_out("prod_clear", 2'b00, 1'b0);
        idle_inputs();
        tick();

        // Consumer ch0: 3 stall cycles, handshake, then 4 more stall cycles
        ch_tvalid = 2'b00;
        ch_tready = 2'b01;
        for (int k = 1; k <= 3; k++) begin
            tick();
            check_out($sformatf("cons_pre.c%0d", k), 2'b00, 1'b0);
        end
        ch_tvalid = 2'b01;                      // handshake in cycle 3
        tick();
        check_out("cons_hs", 2'b00, 1'b0);
        ch_tvalid = 2'b00;                      // stall restarts in cycle 4
        for (int k = 5; k <= 7; k++) begin
            tick();
            check_out($sformatf("cons_post.c%0d", k), 2'b00, 1'b0);
        end
        tick();
        check_out("cons_block.c8", 2'b01, 1'b1);
        idle_inputs();
        tick();
        check_out("cons_clear", 2'b00, 1'b0);

        // Threshold 0 acts as 1: single stall cycle on ch0
        threshold = 16'd0;
        ch_tready = 2'b01;
        tick();
        check_out("thr0.c1", 2'b01, 1'b1);
        idle_inputs();
        tick();
        check_out("thr0.c2", 2'b00, 1'b0);

        // Both channels together, threshold 2: one shared event
        threshold = 16'd2;
        ch_tvalid = 2'b10;
        ch_tready = 2'b01;
        tick();
        check_out("both.c1", 2'b00, 1'b0);
        tick();
        check_out("both.c2", 2'b11, 1'b1);
        tick();
        check_out("both.c3", 2'b11, 1'b0);
        idle_inputs();
        tick();
        check_out("both.clear", 2'b00, 1'b0);

        // Lowering threshold mid-WAIT, then raising it while BLOCKED
        threshold = 16'd10;
        ch_tvalid = 2'b10;
        ticks(3);
        check_out("lower.c3", 2'b00, 1'b0);
        threshold = 16'd2;
        tick();
        check_out("lower.c4", 2'b10, 1'b1);
        threshold = 16'd100;
        tick();
        check_out("raise.c5", 2'b10, 1'b0);
        idle_inputs();
        tick();

        // Enable low forces idle; re-enable restarts the count
        threshold = 16'd2;
        ch_tvalid = 2'b10;
        ticks(2);
        check_out("en.block", 2'b10, 1'b1);
        enable = 1'b0;
        tick();
        check_out("en.off", 2'b00, 1'b0);
        enable = 1'b1;
        tick();
        check_out("en.restart1", 2'b00, 1'b0);
        tick();
        check_out("en.restart2", 2'b10, 1'b1);
        idle_inputs();
        tick();

        // Reset during cycle 3 of a 10-cycle stall, threshold 5
        threshold = 16'd5;
        ch_tvalid = 2'b10;
        ticks(3);
        reset = 1'b1;
        tick();
        check_out("rst.mid", 2'b00, 1'b0);
`ifdef HLS_STALL_MAX_TRACK_EN
        check("rst.stall_max", 32'(stall_max), 32'd0);
`endif
        reset = 1'b0;                           // stall continues from cycle 4
        ticks(4);
        check_out("rst.c8", 2'b00, 1'b0);
        tick();
        check_out("rst.c9", 2'b10, 1'b1);
        idle_inputs();
        tick();
        check_out("rst.clear", 2'b00, 1'b0);

`ifdef HLS_STALL_MAX_TRACK_EN
        // Longest stall: 7 then 3 cycles
        stats_clear = 1'b1;
        tick();
        stats_clear = 1'b0;
        check("max.clear0", 32'(stall_max), 32'd0);
        threshold = 16'd100;
        ch_tvalid = 2'b10;
        ticks(7);
        idle_inputs();
        tick();
        ch_tready = 2'b01;
        ticks(3);
        idle_inputs();
        tick();
        check("max.7_3", 32'(stall_max), 32'd7);
        stats_clear = 1'b1;
        tick();
        stats_clear = 1'b0;
        check("max.clear", 32'(stall_max), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
